// File: rtl/bloom_pkg.sv
// Shared definitions for the Bloom filter sweep writer.
// Contents: op encodings, sweep FSM state type, default widths and an op normaliser.
package bloom_pkg;

  localparam int unsigned DefaultN = 32;
  localparam int unsigned DefaultM = 64;

  localparam logic [1:0] OP_INSERT = 2'd0;
  localparam logic [1:0] OP_QUERY  = 2'd1;
  localparam logic [1:0] OP_CLEAR  = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_e;

  // The reserved encoding behaves exactly like a query.
  function automatic logic [1:0] normalize_op(input logic [1:0] op);
    return (op == OP_INSERT || op == OP_CLEAR) ? op : OP_QUERY;
  endfunction

endpackage

// File: rtl/bloom_sweep_writer_if.sv
// Request/result bundle of the Bloom filter sweep writer.
// Request : in_valid, in_ready, in_op, in_index
// Result  : out_valid, out_ready, out_hit, out_range_err
// State   : filter_bits (registered filter array)
// master drives requests and accepts results; slave is the writer itself.
interface bloom_sweep_writer_if
  import bloom_pkg::*;
#(
  parameter int unsigned N = DefaultN,
  parameter int unsigned M = DefaultM
);
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   in_op;
  logic [N-1:0] in_index;
  logic         out_valid;
  logic         out_ready;
  logic         out_hit;
  logic         out_range_err;
  logic [M-1:0] filter_bits;

  modport master (
    output in_valid, in_op, in_index, out_ready,
    input  in_ready, out_valid, out_hit, out_range_err, filter_bits
  );

  modport slave (
    input  in_valid, in_op, in_index, out_ready,
    output in_ready, out_valid, out_hit, out_range_err, filter_bits
  );
endinterface

// File: rtl/bloom_index_match.sv
// N-bit equality compare of the sweep position against the latched target.
// Ports: counter, target (N bits) in; match (1 bit) out.
module bloom_index_match #(
  parameter int unsigned N = 32
) (
  input  logic [N-1:0] counter,
  input  logic [N-1:0] target,
  output logic         match
);
  assign match = ~|(counter ^ target);
endmodule

// File: rtl/bloom_sweep_writer.sv
// Sequential Bloom filter writer: accepts one hashed index per request and sweeps a
// position counter over all M filter bits, inserting, querying or clearing the owned
// array, then holds the result until the downstream stage takes it.
// Ports: clk, rst (synchronous, active-high), bus (bloom_sweep_writer_if.slave).
// Optional: define BLOOM_EARLY_EXIT_EN to end insert/query sweeps on the match position
// and to skip the sweep entirely for out-of-range insert/query indices.
module bloom_sweep_writer
  import bloom_pkg::*;
#(
  parameter int unsigned N = DefaultN,
  parameter int unsigned M = DefaultM
) (
  input logic                 clk,
  input logic                 rst,
  bloom_sweep_writer_if.slave bus
);

  localparam int unsigned    IdxW    = $clog2(M);
  localparam logic [N-1:0]   LastPos = N'(M - 1);
  localparam logic [N:0]     MBound  = (N + 1)'(M);

  state_e       state_q, state_d;
  logic [1:0]   op_q, op_d;
  logic [N-1:0] target_q, target_d;
  logic [N-1:0] counter_q, counter_d;
  logic         hit_q, hit_d;
  logic         range_err_q, range_err_d;
  logic [M-1:0] filter_q, filter_d;
  logic         match;
  logic         in_oor;
  logic [1:0]   in_op_norm;
  logic [IdxW-1:0] pos;

  bloom_index_match #(
    .N (N)
  ) u_match (
    .counter (counter_q),
    .target  (target_q),
    .match   (match)
  );

  assign in_oor     = ({1'b0, bus.in_index} >= MBound);
  assign in_op_norm = normalize_op(bus.in_op);
  // counter stays below M while sweeping, so the low bits address the array.
  assign pos        = counter_q[IdxW-1:0];

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    target_d    = target_q;
    counter_d   = counter_q;
    hit_d       = hit_q;
    range_err_d = range_err_q;
    filter_d    = filter_q;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          op_d        = in_op_norm;
          target_d    = bus.in_index;
          counter_d   = '0;
          hit_d       = 1'b0;
          range_err_d = in_oor;
          state_d     = SWEEP;
`ifdef BLOOM_EARLY_EXIT_EN
          if (in_oor && (in_op_norm != OP_CLEAR)) begin
            state_d = DONE;
          end
`endif
        end
      end

      SWEEP: begin
        case (op_q)
          OP_INSERT: if (match) filter_d[pos] = 1'b1;
          OP_CLEAR:  filter_d[pos] = 1'b0;
          default:   hit_d = hit_q | (match & filter_q[pos]);
        endcase
        if (counter_q == LastPos) begin
          state_d = DONE;
        end else begin
          counter_d = counter_q + 1'b1;
        end
`ifdef BLOOM_EARLY_EXIT_EN
        if (match && (op_q != OP_CLEAR)) begin
          state_d = DONE;
        end
`endif
      end

      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      op_q        <= OP_INSERT;
      target_q    <= '0;
      counter_q   <= '0;
      hit_q       <= 1'b0;
      range_err_q <= 1'b0;
      filter_q    <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      target_q    <= target_d;
      counter_q   <= counter_d;
      hit_q       <= hit_d;
      range_err_q <= range_err_d;
      filter_q    <= filter_d;
    end
  end

  assign bus.in_ready      = (state_q == IDLE);
  assign bus.out_valid     = (state_q == DONE);
  // hit is only ever raised by queries, so insert/clear report 0.
  assign bus.out_hit       = (state_q == DONE) & hit_q;
  assign bus.out_range_err = (state_q == DONE) & range_err_q;
  assign bus.filter_bits   = filter_q;

endmodule

// File: tb/tb_bloom_sweep_writer.sv
// Scoreboard bench for bloom_sweep_writer: a driver issues directed and random requests,
// a filter model predicts each result, and a monitor checks results as they appear.
module tb_bloom_sweep_writer;

  localparam int unsigned N = 32;
  localparam int unsigned M = 64;

  typedef struct {
    logic        hit;
    logic        rerr;
    logic [63:0] bits;
    int          acc;
    int          lat;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   n_cmp;
  int   n_fail;
  logic bp_hold;
  logic active;
  exp_t cur;
  exp_t sb_q[$];
  bit   model[M];

  bloom_sweep_writer_if #(.N(N), .M(M)) bus ();

  bloom_sweep_writer #(.N(N), .M(M)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] model_vec();
    logic [63:0] v;
    for (int i = 0; i < M; i++) v[i] = model[i];
    return v;
  endfunction

  // Reference behaviour: applies one request to the model and returns what it must report.
  function automatic exp_t predict(input logic [1:0] op, input logic [31:0] idx);
    exp_t e;
    bit inr;
    inr    = (idx < M);
    e.hit  = 1'b0;
    e.rerr = !inr;
    if (op == 2'd0) begin
      if (inr) model[idx] = 1'b1;
    end else if (op == 2'd2) begin
      for (int i = 0; i < M; i++) model[i] = 1'b0;
    end else begin
      e.hit = inr && model[idx];
    end
    e.bits = model_vec();
    e.lat  = M + 1;
`ifdef BLOOM_EARLY_EXIT_EN
    if (op != 2'd2) e.lat = inr ? int'(idx) + 2 : 1;
`endif
    return e;
  endfunction

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("in_ready_timeout", 64'd0, 64'd1);
  endtask

  task automatic send(input logic [1:0] op, input logic [31:0] idx);
    exp_t e;
    bit   ok;
    wait_ready(ok);
    if (!ok) return;
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_index = idx;
    e     = predict(op, idx);
    e.acc = cyc;
    sb_q.push_back(e);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (sb_q.size() == 0 && !active && bus.in_ready) return;
    end
    check("drain_timeout", 64'(sb_q.size()), 64'd0);
  endtask

  // Downstream acceptance: random backpressure unless explicitly held off.
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1 bus.out_ready = bp_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: pops one expectation when a result first appears, rechecks while it is held.
  initial active = 1'b0;
  always @(negedge clk) begin
    if (!rst && bus.out_valid) begin
      if (!active) begin
        if (sb_q.size() == 0) begin
          check("unexpected_out_valid", 64'd1, 64'd0);
        end else begin
          cur    = sb_q.pop_front();
          active = 1'b1;
          check("latency", 64'(cyc - cur.acc), 64'(cur.lat));
          check("filter_bits", bus.filter_bits, cur.bits);
        end
      end
      if (active) begin
        check("out_hit", 64'(bus.out_hit), 64'(cur.hit));
        check("out_range_err", 64'(bus.out_range_err), 64'(cur.rerr));
        check("in_ready_in_done", 64'(bus.in_ready), 64'd0);
        if (bus.out_ready) active = 1'b0;
      end
    end
  end

  initial begin
    bit ok;
    logic [1:0]  op;
    logic [31:0] idx;
    int r;
    n_cmp = 0;
    n_fail = 0;
    bp_hold = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_op = 2'd0;
    bus.in_index = '0;
    for (int i = 0; i < M; i++) model[i] = 1'b0;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_filter_bits", bus.filter_bits, 64'd0);
    check("reset_in_ready", 64'(bus.in_ready), 64'd1);
    check("reset_out_valid", 64'(bus.out_valid), 64'd0);

    send(2'd0, 32'd5);
    drain();
    check("insert5_bits", bus.filter_bits, 64'h20);
    send(2'd1, 32'd5);
    send(2'd1, 32'd6);
    send(2'd0, 32'd64);
    send(2'd1, 32'd200);
    send(2'd0, 32'd5);
    send(2'd3, 32'd5);
    send(2'd0, 32'd3);
    drain();

    // Hold a query result for 10 cycles; the monitor rechecks it each cycle.
    bp_hold = 1'b1;
    send(2'd1, 32'd3);
    for (int i = 0; i < 200 && !bus.out_valid; i++) @(negedge clk);
    repeat (10) @(negedge clk);
    check("bp_out_valid_held", 64'(bus.out_valid), 64'd1);
    bp_hold = 1'b0;
    send(2'd2, 32'd9);
    drain();
    check("clear_bits", bus.filter_bits, 64'd0);

    for (int t = 0; t < 40; t++) begin
      r = $urandom_range(0, 9);
      op = (r < 5) ? 2'd0 : (r < 8) ? 2'd1 : (r == 8) ? 2'd3 : 2'd2;
      r = $urandom_range(0, 9);
      idx = (r < 6) ? 32'($urandom_range(0, 15)) :
            (r < 8) ? 32'($urandom_range(0, M - 1)) : 32'(M + $urandom_range(0, 1000));
      send(op, idx);
    end
    drain();

    // Abort an insert part-way through its sweep.
    send(2'd0, 32'd7);
    drain();
    wait_ready(ok);
    if (ok) begin
      bus.in_valid = 1'b1;
      bus.in_op = 2'd0;
      bus.in_index = 32'd40;
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      repeat (29) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < M; i++) model[i] = 1'b0;
      @(negedge clk);
      check("abort_filter_bits", bus.filter_bits, 64'd0);
      check("abort_in_ready", 64'(bus.in_ready), 64'd1);
      for (int i = 0; i < M + 4; i++) begin
        @(negedge clk);
        if (bus.out_valid) check("abort_out_valid", 64'd1, 64'd0);
      end
    end

    send(2'd0, 32'd3);
    send(2'd1, 32'd3);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
